wb_ctrl: RTL and testbench
==========================

// Module: wb_ctrl
// PURPOSE
//  Writeback/control stage directly downstream of the memory stage. Consumes the MEM/WB
//  register fields, drives GPR writeback, owns control registers (status, EPC, cause, vector,
//  int mask), takes precise exceptions/interrupts, and generates per-stage stall/flush + new_pc.
// PARAMETERS
//  IRQ_CH   8  number of external interrupt lines
//  SYNC_STG 2  irq synchronizer depth (>=2)
// PORTS
//  clk            in  1           clock, rising edge
//  reset_         in  1           reset, asynchronous, active-low
//  mem_pc         in  WordAddrBus PC of instruction in MEM/WB
//  mem_en         in  1           MEM/WB entry valid
//  mem_br_flag    in  1           instruction is in a branch delay slot
//  mem_ctrl_op    in  CtrlOpBus   NOP / WRCR / EXRT
//  mem_dst_addr   in  RegAddrBus  GPR or creg destination
//  mem_gpr_we_    in  1           GPR write enable, active-low
//  mem_exp_code   in  IsaExpBus   exception raised upstream
//  mem_out        in  WordDataBus result / creg write data
//  if_busy, mem_busy, ld_hazard  in 1 each   stall sources
//  irq            in  IRQ_CH      async interrupt requests, active-high
//  creg_rd_addr   in  RegAddrBus  creg read address (ID stage)
//  creg_rd_data   out WordDataBus comb. read data; unmapped addr -> 0
//  gpr_we_, gpr_wr_addr, gpr_wr_data  out 1/RegAddrBus/WordDataBus  writeback port
//  exe_mode, int_en  out 1 each  current mode (1=KERNEL), global int enable
//  if_stall, id_stall, ex_stall, mem_stall  out 1 each
//  if_flush, id_flush, ex_flush, mem_flush  out 1 each
//  new_pc         out WordAddrBus redirect target, valid while flushes asserted
// BEHAVIOUR
//  - Reset: exe_mode=KERNEL, int_en=0, pre_*=same, epc=0, exp_vector=0, cause=0,
//    int_mask=all 1 (masked), sync flops=0. Outputs are comb. of these: gpr_we_=1, flushes=0.
//  - stall = if_busy|mem_busy. if_stall=stall|ld_hazard; id/ex/mem_stall=stall.
//  - irq passes SYNC_STG flops; irq_det = int_en & |(irq_sync & ~int_mask).
//  - eff_code = mem_exp_code!=NO_EXP ? mem_exp_code : irq_det ? EXT_INT : NO_EXP; only when
//    mem_en=1 (bubbles never trap, pending irq waits for next valid instruction).
//  - take = mem_en & ~stall & (eff_code!=NO_EXP | ctrl_op==EXRT). take -> all four flushes=1
//    same cycle (comb.); new_pc = exp_vector for exception, epc for EXRT.
//  - Exception (eff_code!=NO_EXP) at edge: pre_exe_mode<=exe_mode, pre_int_en<=int_en,
//    exe_mode<=KERNEL, int_en<=0, epc<=mem_br_flag ? mem_pc-1 : mem_pc (30-bit wrap),
//    cause<={mem_br_flag,eff_code}. Instruction not retired: gpr_we_ forced 1, no creg write.
//  - EXRT (no exception): exe_mode<=pre_exe_mode, int_en<=pre_int_en.
//  - WRCR (mem_en, no exception, ~stall): creg[mem_dst_addr]<=mem_out; STATUS={int_en,exe_mode}
//    in bits[1:0]; IRQ register (6) read-only, writes ignored.
//  - Creg map: 0 STATUS, 1 PRE_STATUS, 2 EPC, 3 EXP_VECTOR, 4 CAUSE, 5 INT_MASK, 6 IRQ.
//  - Writeback: gpr_we_ = ~(mem_en & ~mem_gpr_we_ & eff_code==NO_EXP) | stall;
//    gpr_wr_addr=mem_dst_addr, gpr_wr_data=mem_out.
//  - Stall dominates: no creg update, no flush, no writeback while stall=1.
//  - Reset mid-exception: all state returns to reset values asynchronously; no partial update.
// STRUCTURE
//  - Shared header: ctrl-op, exception-code, exe-mode encodings, creg addresses,
//    bus-width defines (WordAddrBus 30b, WordDataBus 32b, RegAddrBus 5b, IsaExpBus 3b).
//  - One sub-module: irq_sync (parameterised SYNC_STG x IRQ_CH synchronizer, async reset_).
// TESTING
//  - Reset: reset_=0 mid-run -> exe_mode=1, int_en=0, int_mask=8'hFF, gpr_we_=1, flushes=0.
//  - Writeback: mem_en=1, gpr_we_=0, dst=5, out=32'hDEAD_BEEF -> gpr write r5 same cycle;
//    mem_busy=1 -> gpr_we_=1, all *_stall=1, if_stall=1 on ld_hazard alone only.
//  - Trap: exp_code=TRAP, pc=30'h100, br_flag=1 -> flushes=1, new_pc=exp_vector, epc=30'h0FF,
//    cause={1,TRAP}, exe_mode=1, int_en=0, no GPR write.
//  - Interrupt: WRCR mask=8'hFE, int_en=1, irq[0]=1 -> EXT_INT after SYNC_STG cycles on next
//    valid instr; irq[1] (masked) -> no trap; mem_en=0 bubble -> no trap until valid.
//  - EXRT: after trap from user mode, EXRT -> new_pc=epc, exe_mode/int_en restored, flushes=1.
//  - Creg RW: WRCR each addr 0-6 then read back via creg_rd_addr; addr 6 unchanged, 9 -> 0.

Source files
------------

// File: rtl/wb_ctrl_pkg.sv
// Shared encodings and bus widths for the writeback/control stage.
// Holds ctrl-op, exception-code, exe-mode encodings, creg map and packed register layouts.
package wb_ctrl_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int ISA_EXP_W   = 3;
    localparam int CTRL_OP_W   = 2;
    localparam int BYTE_OFS_W  = 2;

    typedef enum logic [CTRL_OP_W-1:0] {
        CTRL_OP_NOP  = 2'd0,
        CTRL_OP_WRCR = 2'd1,
        CTRL_OP_EXRT = 2'd2
    } ctrl_op_e;

    typedef enum logic [ISA_EXP_W-1:0] {
        EXP_NO_EXP     = 3'd0,
        EXP_EXT_INT    = 3'd1,
        EXP_UNDEF_INSN = 3'd2,
        EXP_OVERFLOW   = 3'd3,
        EXP_MISS_ALIGN = 3'd4,
        EXP_TRAP       = 3'd5,
        EXP_PRV_VIO    = 3'd6
    } isa_exp_e;

    localparam logic EXE_MODE_USER   = 1'b0;
    localparam logic EXE_MODE_KERNEL = 1'b1;

    localparam logic [REG_ADDR_W-1:0] CREG_STATUS     = 5'd0;
    localparam logic [REG_ADDR_W-1:0] CREG_PRE_STATUS = 5'd1;
    localparam logic [REG_ADDR_W-1:0] CREG_EPC        = 5'd2;
    localparam logic [REG_ADDR_W-1:0] CREG_EXP_VECTOR = 5'd3;
    localparam logic [REG_ADDR_W-1:0] CREG_CAUSE      = 5'd4;
    localparam logic [REG_ADDR_W-1:0] CREG_INT_MASK   = 5'd5;
    localparam logic [REG_ADDR_W-1:0] CREG_IRQ        = 5'd6;

    typedef struct packed {
        logic int_en;
        logic exe_mode;
    } status_t;

    typedef struct packed {
        logic                 br_flag;
        logic [ISA_EXP_W-1:0] exp_code;
    } cause_t;

    // A trapped delay-slot instruction resumes at its branch so the branch re-executes.
    function automatic logic [WORD_ADDR_W-1:0] epc_of(input logic [WORD_ADDR_W-1:0] pc,
                                                      input logic br_flag);
        return br_flag ? pc - WORD_ADDR_W'(1) : pc;
    endfunction

endpackage

// File: rtl/wb_ctrl_irq_sync.sv
// Purpose: multi-flop synchronizer for the asynchronous interrupt request lines.
// Latency: SYNC_STG core cycles from irq edge to irq_sync.
// Backpressure: none; free-running every cycle.
module wb_ctrl_irq_sync #(
    parameter int IRQ_CH   = 8,
    parameter int SYNC_STG = 2
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic [IRQ_CH-1:0] irq,
    output logic [IRQ_CH-1:0] irq_sync
);

    logic [IRQ_CH-1:0] stg [SYNC_STG];

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < SYNC_STG; i++) stg[i] <= '0;
        end else begin
            stg[0] <= irq;
            for (int i = 1; i < SYNC_STG; i++) stg[i] <= stg[i-1];
        end
    end

    assign irq_sync = stg[SYNC_STG-1];

endmodule

// File: rtl/wb_ctrl.sv
// Purpose: writeback/control stage - GPR writeback, control registers, precise traps, pipeline redirect.
// Latency: writeback, flush and new_pc are combinational on MEM/WB fields; creg state updates at the next edge.
// Backpressure: if_busy|mem_busy freezes the stage - no writeback, no creg update, no flush.
module wb_ctrl
    import wb_ctrl_pkg::*;
#(
    parameter int IRQ_CH   = 8,
    parameter int SYNC_STG = 2
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic [WORD_ADDR_W-1:0] mem_pc,
    input  logic                   mem_en,
    input  logic                   mem_br_flag,
    input  logic [CTRL_OP_W-1:0]   mem_ctrl_op,
    input  logic [REG_ADDR_W-1:0]  mem_dst_addr,
    input  logic                   mem_gpr_we_,
    input  logic [ISA_EXP_W-1:0]   mem_exp_code,
    input  logic [WORD_DATA_W-1:0] mem_out,
    input  logic                   if_busy,
    input  logic                   mem_busy,
    input  logic                   ld_hazard,
    input  logic [IRQ_CH-1:0]      irq,
    input  logic [REG_ADDR_W-1:0]  creg_rd_addr,
    output logic [WORD_DATA_W-1:0] creg_rd_data,
    output logic                   gpr_we_,
    output logic [REG_ADDR_W-1:0]  gpr_wr_addr,
    output logic [WORD_DATA_W-1:0] gpr_wr_data,
    output logic                   exe_mode,
    output logic                   int_en,
    output logic                   if_stall,
    output logic                   id_stall,
    output logic                   ex_stall,
    output logic                   mem_stall,
    output logic                   if_flush,
    output logic                   id_flush,
    output logic                   ex_flush,
    output logic                   mem_flush,
    output logic [WORD_ADDR_W-1:0] new_pc
);

    status_t                cur_st;
    status_t                pre_st;
    logic [WORD_ADDR_W-1:0] epc;
    logic [WORD_ADDR_W-1:0] exp_vector;
    cause_t                 cause;
    logic [IRQ_CH-1:0]      int_mask;
    logic [IRQ_CH-1:0]      irq_sync;

    logic                   stall;
    logic                   irq_det;
    logic [ISA_EXP_W-1:0]   eff_code;
    logic                   exp_take;
    logic                   exrt_take;
    logic                   wrcr_take;

    wb_ctrl_irq_sync #(
        .IRQ_CH   (IRQ_CH),
        .SYNC_STG (SYNC_STG)
    ) u_irq_sync (
        .clk      (clk),
        .reset_   (reset_),
        .irq      (irq),
        .irq_sync (irq_sync)
    );

    assign stall   = if_busy | mem_busy;
    assign irq_det = cur_st.int_en & (|(irq_sync & ~int_mask));

    // Bubbles never trap; a pending interrupt rides on the next valid instruction.
    always_comb begin
        eff_code = EXP_NO_EXP;
        if (mem_en) begin
            if (mem_exp_code != EXP_NO_EXP) eff_code = mem_exp_code;
            else if (irq_det)               eff_code = EXP_EXT_INT;
        end
    end

    assign exp_take  = mem_en & ~stall & (eff_code != EXP_NO_EXP);
    assign exrt_take = mem_en & ~stall & (eff_code == EXP_NO_EXP) & (mem_ctrl_op == CTRL_OP_EXRT);
    assign wrcr_take = mem_en & ~stall & (eff_code == EXP_NO_EXP) & (mem_ctrl_op == CTRL_OP_WRCR);

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cur_st     <= '{int_en: 1'b0, exe_mode: EXE_MODE_KERNEL};
            pre_st     <= '{int_en: 1'b0, exe_mode: EXE_MODE_KERNEL};
            epc        <= '0;
            exp_vector <= '0;
            cause      <= '0;
            int_mask   <= '1;
        end else if (exp_take) begin
            pre_st <= cur_st;
            cur_st <= '{int_en: 1'b0, exe_mode: EXE_MODE_KERNEL};
            epc    <= epc_of(mem_pc, mem_br_flag);
            cause  <= '{br_flag: mem_br_flag, exp_code: eff_code};
        end else if (exrt_take) begin
            cur_st <= pre_st;
        end else if (wrcr_take) begin
            case (mem_dst_addr)
                CREG_STATUS:     cur_st     <= status_t'(mem_out[1:0]);
                CREG_PRE_STATUS: pre_st     <= status_t'(mem_out[1:0]);
                CREG_EPC:        epc        <= mem_out[WORD_DATA_W-1:BYTE_OFS_W];
                CREG_EXP_VECTOR: exp_vector <= mem_out[WORD_DATA_W-1:BYTE_OFS_W];
                CREG_CAUSE:      cause      <= cause_t'(mem_out[ISA_EXP_W:0]);
                CREG_INT_MASK:   int_mask   <= mem_out[IRQ_CH-1:0];
                default:         ;
            endcase
        end
    end

    always_comb begin
        creg_rd_data = '0;
        case (creg_rd_addr)
            CREG_STATUS:     creg_rd_data = WORD_DATA_W'(cur_st);
            CREG_PRE_STATUS: creg_rd_data = WORD_DATA_W'(pre_st);
            CREG_EPC:        creg_rd_data = {epc, {BYTE_OFS_W{1'b0}}};
            CREG_EXP_VECTOR: creg_rd_data = {exp_vector, {BYTE_OFS_W{1'b0}}};
            CREG_CAUSE:      creg_rd_data = WORD_DATA_W'(cause);
            CREG_INT_MASK:   creg_rd_data = WORD_DATA_W'(int_mask);
            CREG_IRQ:        creg_rd_data = WORD_DATA_W'(irq_sync);
            default:         creg_rd_data = '0;
        endcase
    end

    always_comb begin
        gpr_we_     = ~(mem_en & ~mem_gpr_we_ & (eff_code == EXP_NO_EXP)) | stall;
        gpr_wr_addr = mem_dst_addr;
        gpr_wr_data = mem_out;
        exe_mode    = cur_st.exe_mode;
        int_en      = cur_st.int_en;
        if_stall    = stall | ld_hazard;
        id_stall    = stall;
        ex_stall    = stall;
        mem_stall   = stall;
        if_flush    = exp_take | exrt_take;
        id_flush    = exp_take | exrt_take;
        ex_flush    = exp_take | exrt_take;
        mem_flush   = exp_take | exrt_take;
        new_pc      = '0;
        if (exp_take)       new_pc = exp_vector;
        else if (exrt_take) new_pc = epc;
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// Scoreboarded bench for wb_ctrl: expected GPR writes and redirects are queued as stimulus is
// driven and popped by a negedge monitor; creg and mode state are checked directly.
module tb_wb_ctrl;
    import wb_ctrl_pkg::*;

    logic        clk;
    logic        reset_;
    logic [29:0] mem_pc;
    logic        mem_en;
    logic        mem_br_flag;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic        mem_gpr_we_;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;
    logic        if_busy, mem_busy, ld_hazard;
    logic [7:0]  irq;
    logic [4:0]  creg_rd_addr;
    logic [31:0] creg_rd_data;
    logic        gpr_we_;
    logic [4:0]  gpr_wr_addr;
    logic [31:0] gpr_wr_data;
    logic        exe_mode, int_en;
    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic [29:0] new_pc;

    int n_chk  = 0;
    int n_fail = 0;

    logic [36:0] gpr_q [$];
    logic [29:0] pc_q  [$];

    wb_ctrl #(.IRQ_CH(8), .SYNC_STG(2)) dut (
        .clk(clk), .reset_(reset_), .mem_pc(mem_pc), .mem_en(mem_en),
        .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr),
        .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code), .mem_out(mem_out),
        .if_busy(if_busy), .mem_busy(mem_busy), .ld_hazard(ld_hazard), .irq(irq),
        .creg_rd_addr(creg_rd_addr), .creg_rd_data(creg_rd_data), .gpr_we_(gpr_we_),
        .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data), .exe_mode(exe_mode),
        .int_en(int_en), .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
        .mem_stall(mem_stall), .if_flush(if_flush), .id_flush(id_flush),
        .ex_flush(ex_flush), .mem_flush(mem_flush), .new_pc(new_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: every writeback and every redirect must match the next queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_ && gpr_we_ === 1'b0) begin
                if (gpr_q.size() == 0) chk("gpr_unexpected", 32'(gpr_wr_addr), 32'hFFFF_FFFF);
                else begin
                    logic [36:0] e;
                    e = gpr_q.pop_front();
                    chk("gpr_addr", 32'(gpr_wr_addr), 32'(e[36:32]));
                    chk("gpr_data", gpr_wr_data, e[31:0]);
                end
            end
            if (reset_ && if_flush === 1'b1) begin
                chk("flush_all", {29'd0, id_flush & ex_flush & mem_flush}, 32'd1);
                if (pc_q.size() == 0) chk("flush_unexpected", 32'(new_pc), 32'hFFFF_FFFF);
                else chk("new_pc", 32'(new_pc), 32'(pc_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        mem_en = 1'b0; mem_br_flag = 1'b0; mem_ctrl_op = CTRL_OP_NOP; mem_dst_addr = '0;
        mem_gpr_we_ = 1'b1; mem_exp_code = EXP_NO_EXP; mem_out = '0; mem_pc = '0;
        if_busy = 1'b0; mem_busy = 1'b0; ld_hazard = 1'b0;
    endtask

    // Presents one valid MEM/WB entry for exactly one cycle, aligned to posedge+1.
    task automatic issue(input logic [29:0] pc, input logic [1:0] op, input logic [4:0] dst,
                         input logic gwe_n, input logic [2:0] code, input logic [31:0] dat,
                         input logic br);
        @(posedge clk); #1;
        mem_en = 1'b1; mem_pc = pc; mem_ctrl_op = op; mem_dst_addr = dst;
        mem_gpr_we_ = gwe_n; mem_exp_code = code; mem_out = dat; mem_br_flag = br;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic wrcr(input logic [4:0] addr, input logic [31:0] dat);
        issue(30'h3F0, CTRL_OP_WRCR, addr, 1'b1, EXP_NO_EXP, dat, 1'b0);
    endtask

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        creg_rd_addr = addr; #1;
        chk(tag, creg_rd_data, exp);
    endtask

    initial begin
        idle();
        irq = '0; creg_rd_addr = '0; reset_ = 1'b0;
        #12;
        chk("rst_mode", 32'(exe_mode), 32'd1);
        chk("rst_int_en", 32'(int_en), 32'd0);
        chk("rst_gpr_we", 32'(gpr_we_), 32'd1);
        chk("rst_flush", 32'(if_flush | id_flush | ex_flush | mem_flush), 32'd0);
        rd("rst_int_mask", CREG_INT_MASK, 32'h0000_00FF);
        @(posedge clk); #2; reset_ = 1'b1;

        // Writeback same cycle.
        gpr_q.push_back({5'd5, 32'hDEAD_BEEF});
        issue(30'h10, CTRL_OP_NOP, 5'd5, 1'b0, EXP_NO_EXP, 32'hDEAD_BEEF, 1'b0);

        // Stall dominates writeback and trap.
        mem_en = 1'b1; mem_gpr_we_ = 1'b0; mem_dst_addr = 5'd3; mem_busy = 1'b1; #1;
        chk("stall_gpr_we", 32'(gpr_we_), 32'd1);
        chk("stall_all", 32'({if_stall, id_stall, ex_stall, mem_stall}), 32'hF);
        mem_exp_code = EXP_TRAP; #1;
        chk("stall_no_flush", 32'(if_flush), 32'd0);
        @(posedge clk); #1; idle();
        rd("stall_cause", CREG_CAUSE, 32'd0);
        ld_hazard = 1'b1; #1;
        chk("ldh_if_stall", 32'(if_stall), 32'd1);
        chk("ldh_id_stall", 32'(id_stall | ex_stall | mem_stall), 32'd0);
        ld_hazard = 1'b0;

        // Trap from user mode with interrupts enabled, in a delay slot.
        wrcr(CREG_EXP_VECTOR, 32'h0000_4000);
        rd("vec_rd", CREG_EXP_VECTOR, 32'h0000_4000);
        wrcr(CREG_STATUS, 32'h0000_0002);
        chk("user_mode", 32'({int_en, exe_mode}), 32'h2);
        pc_q.push_back(30'h1000);
        issue(30'h100, CTRL_OP_NOP, 5'd9, 1'b0, EXP_TRAP, 32'h1111_1111, 1'b1);
        chk("trap_mode", 32'(exe_mode), 32'd1);
        chk("trap_int_en", 32'(int_en), 32'd0);
        rd("trap_epc", CREG_EPC, {30'h0FF, 2'b00});
        rd("trap_cause", CREG_CAUSE, 32'h0000_000D);
        rd("trap_pre", CREG_PRE_STATUS, 32'h0000_0002);

        // Return restores mode and interrupt enable.
        pc_q.push_back(30'h0FF);
        issue(30'h2000, CTRL_OP_EXRT, 5'd0, 1'b1, EXP_NO_EXP, 32'd0, 1'b0);
        chk("exrt_mode", 32'(exe_mode), 32'd0);
        chk("exrt_int_en", 32'(int_en), 32'd1);

        // Interrupts: masked line ignored, sync depth honoured, bubbles never trap.
        wrcr(CREG_INT_MASK, 32'h0000_00FE);
        irq = 8'h02;
        repeat (4) @(posedge clk);
        issue(30'h180, CTRL_OP_NOP, 5'd0, 1'b1, EXP_NO_EXP, 32'd0, 1'b0);
        @(posedge clk); #1; irq = 8'h01;
        issue(30'h190, CTRL_OP_NOP, 5'd0, 1'b1, EXP_NO_EXP, 32'd0, 1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("bubble_no_flush", 32'(if_flush), 32'd0);
        end
        pc_q.push_back(30'h1000);
        issue(30'h200, CTRL_OP_NOP, 5'd7, 1'b0, EXP_NO_EXP, 32'h2222_2222, 1'b0);
        rd("irq_cause", CREG_CAUSE, 32'h0000_0001);
        rd("irq_epc", CREG_EPC, {30'h200, 2'b00});
        chk("irq_int_en", 32'(int_en), 32'd0);
        irq = '0;
        repeat (4) @(posedge clk);

        // Control-register write/readback across the whole map.
        wrcr(CREG_STATUS,     32'h0000_0003);
        rd("rw_status", CREG_STATUS, 32'h0000_0003);
        wrcr(CREG_PRE_STATUS, 32'h0000_0002);
        rd("rw_pre", CREG_PRE_STATUS, 32'h0000_0002);
        wrcr(CREG_EPC,        32'h1234_567B);
        rd("rw_epc", CREG_EPC, 32'h1234_5678);
        wrcr(CREG_EXP_VECTOR, 32'hABCD_0004);
        rd("rw_vec", CREG_EXP_VECTOR, 32'hABCD_0004);
        wrcr(CREG_CAUSE,      32'hFFFF_FFFA);
        rd("rw_cause", CREG_CAUSE, 32'h0000_000A);
        wrcr(CREG_INT_MASK,   32'h1234_5655);
        rd("rw_mask", CREG_INT_MASK, 32'h0000_0055);
        wrcr(CREG_IRQ,        32'hFFFF_FFFF);
        rd("rw_irq_ro", CREG_IRQ, 32'h0000_0000);
        rd("rw_unmapped", 5'd9, 32'h0000_0000);

        // Asynchronous reset in mid-cycle.
        @(posedge clk); #3; reset_ = 1'b0; #1;
        chk("mid_rst_mode", 32'(exe_mode), 32'd1);
        chk("mid_rst_int_en", 32'(int_en), 32'd0);
        chk("mid_rst_gpr_we", 32'(gpr_we_), 32'd1);
        chk("mid_rst_flush", 32'(if_flush | id_flush | ex_flush | mem_flush), 32'd0);
        rd("mid_rst_mask", CREG_INT_MASK, 32'h0000_00FF);
        rd("mid_rst_epc", CREG_EPC, 32'h0000_0000);
        rd("mid_rst_vec", CREG_EXP_VECTOR, 32'h0000_0000);
        @(posedge clk); #2; reset_ = 1'b1;
        repeat (2) @(posedge clk);

        chk("gpr_q_drained", 32'(gpr_q.size()), 32'd0);
        chk("pc_q_drained", 32'(pc_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
